// File: rtl/lsrt_uart_rx_fifo_if.sv
// Bus between uart_rx, the receive FIFO and its consumer.
// The master side drives the uart_rx handshake inputs and the consumer controls.
interface lsrt_uart_rx_fifo_if #(
  parameter int DMSB = 7,
  parameter int AMSB = 3
);
  logic            rx_full;
  logic [DMSB:0]   rx_rdata;
  logic            rx_clear;
  logic            pop;
  logic [DMSB:0]   rdata;
  logic            empty;
  logic            full;
  logic [AMSB+1:0] level;
  logic [AMSB+1:0] thr;
  logic            req;
  logic            ovf;
  logic            ovf_clr;

  modport master (
    output rx_full, rx_rdata, pop, thr, ovf_clr,
    input  rx_clear, rdata, empty, full, level, req, ovf
  );

  modport slave (
    input  rx_full, rx_rdata, pop, thr, ovf_clr,
    output rx_clear, rdata, empty, full, level, req, ovf
  );
endinterface

// File: rtl/lsrt_uart_rx_fifo.sv
// Receive byte FIFO behind uart_rx: one write per rx_full handshake,
// registered head data, explicit level count, overflow and threshold flags.
module lsrt_uart_rx_fifo #(
  parameter int DMSB = 7,
  parameter int AMSB = 3
) (
  input logic                  clk,
  input logic                  rstn,
  input logic                  setn,
  lsrt_uart_rx_fifo_if.slave   bus
);
  localparam int              DEPTH    = 2**(AMSB+1);
  localparam logic [AMSB+1:0] LVL_FULL = (AMSB+2)'(DEPTH);
  localparam logic [AMSB+1:0] LVL_ONE  = (AMSB+2)'(1);
  localparam logic [AMSB:0]   PTR_ONE  = (AMSB+1)'(1);

  typedef enum logic [1:0] {IDLE, WR, ACK} state_t;

  state_t                  state, state_nxt;
  logic [DEPTH-1:0][DMSB:0] mem;
  logic [AMSB:0]           wr_ptr, rd_ptr, rd_nxt;
  logic [AMSB+1:0]         level, level_nxt;
  logic [DMSB:0]           rdata_q;
  logic                    rx_clear_q, req_q, ovf_q;
  logic                    empty, full, cap, pop_ok, wr_ok, drop, clr_nxt;

  assign empty  = (level == '0);
  assign full   = (level == LVL_FULL);
  assign pop_ok = bus.pop & ~empty;
  // A pop on the capture edge frees the slot, so a full FIFO still accepts.
  assign wr_ok  = cap & (~full | pop_ok);
  assign drop   = cap & full & ~bus.pop;
  assign rd_nxt = rd_ptr + PTR_ONE;

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      state <= IDLE;
    else if (!setn) state <= IDLE;
    else            state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.rx_full) state_nxt = WR;
      WR:      state_nxt = ACK;
      ACK:     if (!bus.rx_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cap     = (state == IDLE) & bus.rx_full;
    clr_nxt = (state_nxt != IDLE);
  end

  always_comb begin
    level_nxt = level;
    case ({wr_ok, pop_ok})
      2'b10:   level_nxt = level + LVL_ONE;
      2'b01:   level_nxt = level - LVL_ONE;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (setn && wr_ok) mem[wr_ptr] <= bus.rx_rdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      rdata_q    <= '0;
      req_q      <= 1'b0;
      ovf_q      <= 1'b0;
      rx_clear_q <= 1'b0;
    end else if (!setn) begin
      // Flush, but keep clear high so uart_rx is never stuck holding full.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      rdata_q    <= '0;
      req_q      <= 1'b0;
      ovf_q      <= 1'b0;
      rx_clear_q <= 1'b1;
    end else begin
      rx_clear_q <= clr_nxt;
      if (wr_ok)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok) rd_ptr <= rd_nxt;
      level <= level_nxt;
      req_q <= (bus.thr != '0) && (level_nxt >= bus.thr);
      if (drop)             ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
      // Head register: on pop show the next entry (bypassing the write when
      // the only successor is arriving this edge); otherwise track mem[head].
      if (pop_ok) begin
        if (level > LVL_ONE) rdata_q <= mem[rd_nxt];
        else if (wr_ok)      rdata_q <= bus.rx_rdata;
      end else if (!empty) begin
        rdata_q <= mem[rd_ptr];
      end
    end
  end

  assign bus.rx_clear = rx_clear_q;
  assign bus.rdata    = rdata_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.level    = level;
  assign bus.req      = req_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_lsrt_uart_rx_fifo.sv
// Directed bench for lsrt_uart_rx_fifo: a byte scoreboard queue is filled as
// bytes are delivered and drained against rdata as they are popped.
module tb_lsrt_uart_rx_fifo;
  logic clk, rstn, setn;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] sb[$];

  lsrt_uart_rx_fifo_if #(.DMSB(7), .AMSB(3)) bus();

  lsrt_uart_rx_fifo #(.DMSB(7), .AMSB(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .setn (setn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Full uart_rx style handshake; optionally pulse ovf_clr or pop on the capture edge.
  task automatic send_byte(input logic [7:0] b, input bit acc, input bit clr_cap, input bit pop_cap);
    int n;
    logic [7:0] e;
    bus.rx_rdata = b;
    bus.rx_full  = 1'b1;
    if (clr_cap) bus.ovf_clr = 1'b1;
    if (pop_cap) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pop_on_capture_data", {24'h0, bus.rdata}, {24'h0, e});
      end
      bus.pop = 1'b1;
    end
    if (acc) sb.push_back(b);
    tick();
    bus.ovf_clr = 1'b0;
    bus.pop     = 1'b0;
    n = 0;
    while (bus.rx_clear !== 1'b1 && n < 8) begin tick(); n++; end
    chk("rx_clear_assert", {31'h0, bus.rx_clear}, 32'h1);
    tick();
    bus.rx_full = 1'b0;
    tick();
    chk("rx_clear_release", {31'h0, bus.rx_clear}, 32'h0);
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(tag, {24'h0, bus.rdata}, {24'h0, e});
    end
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (sb.size() > 0) pop_one(tag);
    chk({tag, "_empty"}, {31'h0, bus.empty}, 32'h1);
    chk({tag, "_level"}, {27'h0, bus.level}, 32'h0);
  endtask

  initial begin
    rstn = 1'b0; setn = 1'b1;
    bus.rx_full = 1'b0; bus.rx_rdata = 8'h00; bus.pop = 1'b0;
    bus.thr = 5'd0; bus.ovf_clr = 1'b0;
    #12;
    chk("rst_level",    {27'h0, bus.level},    32'h0);
    chk("rst_empty",    {31'h0, bus.empty},    32'h1);
    chk("rst_full",     {31'h0, bus.full},     32'h0);
    chk("rst_req",      {31'h0, bus.req},      32'h0);
    chk("rst_ovf",      {31'h0, bus.ovf},      32'h0);
    chk("rst_rx_clear", {31'h0, bus.rx_clear}, 32'h0);
    chk("rst_rdata",    {24'h0, bus.rdata},    32'h0);
    tick();
    rstn = 1'b1;
    tick();

    // 1: single byte with exact handshake timing
    bus.rx_rdata = 8'h41; bus.rx_full = 1'b1;
    sb.push_back(8'h41);
    tick();
    chk("t1_rx_clear", {31'h0, bus.rx_clear}, 32'h1);
    chk("t1_level",    {27'h0, bus.level},    32'h1);
    chk("t1_empty",    {31'h0, bus.empty},    32'h0);
    tick();
    chk("t1_rdata",    {24'h0, bus.rdata},    32'h41);
    bus.rx_full = 1'b0;
    tick();
    chk("t1_rx_clear_rel", {31'h0, bus.rx_clear}, 32'h0);
    pop_one("t1_pop");
    chk("t1_empty_after", {31'h0, bus.empty}, 32'h1);
    chk("t1_level_after", {27'h0, bus.level}, 32'h0);
    bus.pop = 1'b1; tick(); bus.pop = 1'b0;
    chk("t1_underflow_level", {27'h0, bus.level}, 32'h0);
    chk("t1_underflow_empty", {31'h0, bus.empty}, 32'h1);

    // 2: fill, partial drain, refill across the wrap, full drain
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 1'b0, 1'b0);
    chk("t2_full",  {31'h0, bus.full},  32'h1);
    chk("t2_level", {27'h0, bus.level}, 32'd16);
    for (int i = 0; i < 8; i++) pop_one("t2_order");
    chk("t2_level8", {27'h0, bus.level}, 32'd8);
    for (int i = 16; i < 24; i++) send_byte(8'(i), 1'b1, 1'b0, 1'b0);
    chk("t2_refull", {31'h0, bus.full}, 32'h1);
    drain("t2_order");

    // 3: overflow, clear, and set-beats-clear
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0, 1'b0);
    chk("t3_ovf",   {31'h0, bus.ovf},   32'h1);
    chk("t3_level", {27'h0, bus.level}, 32'd16);
    bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
    chk("t3_ovf_clr", {31'h0, bus.ovf}, 32'h0);
    send_byte(8'hAB, 1'b0, 1'b1, 1'b0);
    chk("t3_ovf_set_wins", {31'h0, bus.ovf}, 32'h1);
    drain("t3_order");
    bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
    chk("t3_ovf_clr2", {31'h0, bus.ovf}, 32'h0);

    // 4: capture coinciding with a pop, full and empty cases
    for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i), 1'b1, 1'b0, 1'b0);
    send_byte(8'h40, 1'b1, 1'b0, 1'b1);
    chk("t4_level_full", {27'h0, bus.level}, 32'd16);
    chk("t4_ovf",        {31'h0, bus.ovf},   32'h0);
    drain("t4_order");
    send_byte(8'h55, 1'b1, 1'b0, 1'b1);
    chk("t4_level_empty", {27'h0, bus.level}, 32'h1);
    drain("t4_empty_case");

    // 5: threshold request
    bus.thr = 5'd4;
    for (int i = 0; i < 3; i++) send_byte(8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
    chk("t5_req_below", {31'h0, bus.req}, 32'h0);
    send_byte(8'h63, 1'b1, 1'b0, 1'b0);
    chk("t5_req_at", {31'h0, bus.req}, 32'h1);
    pop_one("t5_order");
    chk("t5_req_after_pop", {31'h0, bus.req}, 32'h0);
    drain("t5_order");
    bus.thr = 5'd0;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h70 + i), 1'b1, 1'b0, 1'b0);
    chk("t5_req_thr0", {31'h0, bus.req}, 32'h0);
    drain("t5_thr0");

    // 6a: soft flush with the FSM in ACK
    for (int i = 0; i < 5; i++) send_byte(8'(8'h81 + i), 1'b1, 1'b0, 1'b0);
    bus.rx_rdata = 8'h99; bus.rx_full = 1'b1;
    tick(); tick();
    setn = 1'b0;
    tick();
    chk("t6_flush_level",    {27'h0, bus.level},    32'h0);
    chk("t6_flush_empty",    {31'h0, bus.empty},    32'h1);
    chk("t6_flush_rdata",    {24'h0, bus.rdata},    32'h0);
    chk("t6_flush_rx_clear", {31'h0, bus.rx_clear}, 32'h1);
    tick();
    chk("t6_flush_rx_clear_hold", {31'h0, bus.rx_clear}, 32'h1);
    bus.rx_full = 1'b0; setn = 1'b1;
    tick();
    chk("t6_flush_rx_clear_rel", {31'h0, bus.rx_clear}, 32'h0);
    sb.delete();

    // 6b: async reset mid-cycle with the FSM in ACK
    bus.thr = 5'd2;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h91 + i), 1'b1, 1'b0, 1'b0);
    chk("t6_req_pre", {31'h0, bus.req}, 32'h1);
    bus.rx_rdata = 8'h77; bus.rx_full = 1'b1;
    tick(); tick();
    #2 rstn = 1'b0;
    #1;
    chk("t6_arst_level",    {27'h0, bus.level},    32'h0);
    chk("t6_arst_empty",    {31'h0, bus.empty},    32'h1);
    chk("t6_arst_full",     {31'h0, bus.full},     32'h0);
    chk("t6_arst_req",      {31'h0, bus.req},      32'h0);
    chk("t6_arst_rdata",    {24'h0, bus.rdata},    32'h0);
    chk("t6_arst_rx_clear", {31'h0, bus.rx_clear}, 32'h0);
    bus.rx_full = 1'b0;
    tick();
    rstn = 1'b1;
    sb.delete();
    tick();
    chk("t6_post_level", {27'h0, bus.level}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsrt_uart_rx_fifo.md
Name: lsrt_uart_rx_fifo

Overview:
Receive-side byte buffer directly downstream of uart_rx. It captures each byte that uart_rx presents with full, returns the clear handshake, and queues the byte in a circular FIFO. Software or a consumer block drains the FIFO through a pop/empty interface. It also flags overflow and raises a level-threshold request. All logic runs on the same clk as uart_rx; no synchronisers are needed.

Parameters:
DMSB, 7, data MSB; byte width is DMSB+1.
AMSB, 3, FIFO address MSB; depth = 2^(AMSB+1) = 16.

Ports:
clk  in  1  system clock, rising edge.
rstn  in  1  asynchronous active-low reset.
setn  in  1  synchronous active-low soft enable; low flushes the block.
rx_full  in  1  from uart_rx full; a received byte is valid on rx_rdata.
rx_rdata  in  DMSB+1  from uart_rx rdata.
rx_clear  out  1  to uart_rx clear; acknowledges and releases the byte.
pop  in  1  consumer read strobe, one entry per cycle while high.
rdata  out  DMSB+1  head-of-FIFO data, registered.
empty  out  1  FIFO holds 0 entries.
full  out  1  FIFO holds depth entries.
level  out  AMSB+2  current entry count, 0..depth.
thr  in  AMSB+2  threshold for req.
req  out  1  level >= thr and thr != 0.
ovf  out  1  sticky overflow flag.
ovf_clr  in  1  clears ovf.

Behaviour:
- Reset (rstn=0, async): pointers=0, level=0, rdata=0, empty=1, full=0, req=0, ovf=0, rx_clear=0, FSM=IDLE.
- setn=0 (sampled at clk):
  - same effect as reset, except rx_clear=1 is held so uart_rx is released.
  - Takes priority over every other event.
- Capture FSM: IDLE, WR, ACK.
  - IDLE: on an edge with rx_full=1, latch rx_rdata into the FIFO tail and go to WR. If the FIFO is full and no pop occurs that cycle, drop the byte, set ovf=1, and still go to WR.
  - WR: rx_clear=1 (registered); go to ACK.
  - ACK: rx_clear stays 1 while rx_full=1. When rx_full is sampled 0, rx_clear goes 0 and the FSM returns to IDLE.
  - Exactly one FIFO write per rx_full assertion, however long rx_full stays high.
  - Minimum capture cycle is 3 clk.
- Write latency: byte captured at edge k → level, empty and full updated after edge k → rdata valid after edge k+1 when the FIFO was empty.
- Pop:
  - With empty=0, a pop high at edge k advances the head; the next entry appears on rdata after edge k. If the FIFO becomes empty, rdata holds its last value.
  - A pop while empty=1 is ignored; level stays 0 and no underflow flag exists.
- Simultaneous write and pop:
  - level is unchanged.
  - When full=1, the write succeeds because the pop frees the slot in the same edge; no overflow.
  - When empty=1, the write proceeds and the pop is ignored.
- Pointers are AMSB+1 bits and wrap modulo depth. level is the explicit AMSB+2-bit count, never derived from the pointers.
- full is 1 iff level == depth; empty is 1 iff level == 0; req is registered together with level.
- ovf: set on a dropped byte and cleared by ovf_clr. If both occur in the same cycle, set wins.
- Reset in mid-capture (rstn or setn low in WR or ACK): the FSM goes to IDLE and any queued data is lost. rx_clear follows the reset rules above, so uart_rx is never left holding full forever while setn=0.

Test Plan:
1. Single byte: after reset and setn=1, drive rx_rdata=8'h41 and rx_full=1 until rx_clear is seen, then 0. Require level=1, empty=0, rdata=8'h41 two cycles after capture, and rx_clear deasserted one cycle after rx_full falls. Then pop for one cycle: empty=1, level=0.
2. Fill and wrap: write 16 bytes 0x00..0x0F → full=1, level=16. Pop 8, write 0x10..0x17, pop all 16. Required read order is 0x00..0x17 with no gaps, exercising pointer wrap.
3. Overflow: with the FIFO full, deliver byte 0xAA → ovf=1, level=16, 0xAA absent from the pops, rx_clear still handshakes. Pulse ovf_clr → ovf=0. Pulse ovf_clr on the same cycle as a new drop → ovf stays 1.
4. Simultaneous: with the FIFO full, capture edge coincides with a pop → level stays 16, ovf=0, and the new byte is read last. With the FIFO empty, capture coincides with a pop → level=1.
5. Threshold: thr=4, write 3 bytes → req=0; 4th byte → req=1 after the write edge; pop once → req=0. thr=0 → req never asserts.
6. Flush and reset: with 5 entries queued and FSM in ACK, drop setn for one cycle → level=0, empty=1, rx_clear=1 while setn=0. Repeat with async rstn pulsed mid-cycle → all outputs at reset values immediately, without waiting for a clk edge.
